// File: rtl/operand_fwd_stage.sv
// Registered operand-select stage: picks Bus_A/Bus_B sources, forwards the youngest
// in-flight result, stalls on load-use and hands operands over a valid/ready register.
module operand_fwd_stage #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 16,
    parameter int IM_W    = 15,
    parameter int AW      = 5,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AW-1:0]             sa,
    input  logic [AW-1:0]             sb,
    input  logic [DATA_W-1:0]         A_Data,
    input  logic [DATA_W-1:0]         B_Data,
    input  logic [PC_W-1:0]           PC_1,
    input  logic [IM_W-1:0]           IM,
    input  logic                      CS,
    input  logic                      MA,
    input  logic                      MB,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD*AW-1:0]     fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic [NUM_FWD-1:0]        fwd_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         Bus_A,
    output logic [DATA_W-1:0]         Bus_B,
    output logic [CNT_W-1:0]          stall_cnt
);

    logic              a_hit, b_hit;
    logic              a_fwd_rdy, b_fwd_rdy;
    logic [DATA_W-1:0] a_fwd_data, b_fwd_data;
    logic [DATA_W-1:0] pc_ext, im_ext;
    logic [DATA_W-1:0] a_sel, b_sel;
    logic              hazard, capture;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        a_hit      = 1'b0;
        a_fwd_rdy  = 1'b1;
        a_fwd_data = '0;
        b_hit      = 1'b0;
        b_fwd_rdy  = 1'b1;
        b_fwd_data = '0;
        // Scan oldest to youngest so the lowest matching index is written last and wins.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_addr[i*AW +: AW] == sa && sa != '0) begin
                a_hit      = 1'b1;
                a_fwd_rdy  = fwd_ready[i];
                a_fwd_data = fwd_data[i*DATA_W +: DATA_W];
            end
            if (fwd_valid[i] && fwd_addr[i*AW +: AW] == sb && sb != '0) begin
                b_hit      = 1'b1;
                b_fwd_rdy  = fwd_ready[i];
                b_fwd_data = fwd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        pc_ext             = '0;
        pc_ext[PC_W-1:0]   = PC_1;
        im_ext             = {DATA_W{CS & IM[IM_W-1]}};
        im_ext[IM_W-1:0]   = IM;
    end

    assign a_sel = MA ? pc_ext : (a_hit ? a_fwd_data : A_Data);
    assign b_sel = MB ? im_ext : (b_hit ? b_fwd_data : B_Data);

    // A bus fed by PC_1 or the immediate does not depend on the pending load.
    assign hazard   = in_valid & ((~MA & a_hit & ~a_fwd_rdy) | (~MB & b_hit & ~b_fwd_rdy));
    assign in_ready = reset_n & ~hazard & (~out_valid | out_ready);
    assign capture  = in_valid & in_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            out_valid <= 1'b0;
            Bus_A     <= '0;
            Bus_B     <= '0;
            stall_cnt <= '0;
        end else begin
            if (capture) begin
                Bus_A     <= a_sel;
                Bus_B     <= b_sel;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (hazard && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Self-checking bench for operand_fwd_stage: directed plan plus randomized traffic
// compared every cycle against a behavioural model of the operand-select rules.
module tb_operand_fwd_stage;

    localparam int NF = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  sa, sb;
    logic [31:0] a_data, b_data;
    logic [15:0] pc;
    logic [14:0] im;
    logic        cs, ma, mb;
    logic        out_valid, out_ready;
    logic [31:0] bus_a, bus_b;
    logic [15:0] stall_cnt;

    logic        fv [NF];
    logic [4:0]  fa [NF];
    logic [31:0] fd [NF];
    logic        fr [NF];

    logic [NF-1:0]    fwd_valid, fwd_ready;
    logic [NF*5-1:0]  fwd_addr;
    logic [NF*32-1:0] fwd_data;

    always_comb begin
        fwd_valid = '0;
        fwd_ready = '0;
        fwd_addr  = '0;
        fwd_data  = '0;
        for (int i = 0; i < NF; i++) begin
            fwd_valid[i]         = fv[i];
            fwd_ready[i]         = fr[i];
            fwd_addr[i*5 +: 5]   = fa[i];
            fwd_data[i*32 +: 32] = fd[i];
        end
    end

    always #5 clk = ~clk;

    operand_fwd_stage dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sa        (sa),
        .sb        (sb),
        .A_Data    (a_data),
        .B_Data    (b_data),
        .PC_1      (pc),
        .IM        (im),
        .CS        (cs),
        .MA        (ma),
        .MB        (mb),
        .fwd_valid (fwd_valid),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .fwd_ready (fwd_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Bus_A     (bus_a),
        .Bus_B     (bus_b),
        .stall_cnt (stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Model state: what the output register must hold.
    logic        m_valid = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;
    int          m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [4:0] s);
        if (s == 0) return -1;
        for (int i = 0; i < NF; i++)
            if (fv[i] && fa[i] == s) return i;
        return -1;
    endfunction

    // One clock: check in_ready against the rules, advance the model, check the registers.
    task automatic cycle();
        int          wa, wb;
        logic        hz, rdy;
        logic [31:0] na, nb;
        #1;
        wa = winner(sa);
        wb = winner(sb);
        hz = in_valid && ((!ma && wa >= 0 && !fr[wa]) || (!mb && wb >= 0 && !fr[wb]));
        rdy = reset_n && !hz && (!m_valid || out_ready);
        check("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        na = ma ? {16'b0, pc} : (wa >= 0 ? fd[wa] : a_data);
        nb = mb ? (cs ? {{17{im[14]}}, im} : {17'b0, im}) : (wb >= 0 ? fd[wb] : b_data);
        @(posedge clk);
        if (!reset_n) begin
            m_valid = 1'b0;
            m_a     = '0;
            m_b     = '0;
            m_cnt   = 0;
        end else begin
            if (in_valid && rdy) begin
                m_valid = 1'b1;
                m_a     = na;
                m_b     = nb;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (hz && m_cnt < 65535) m_cnt++;
        end
        #1;
        check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("bus_a", bus_a, m_a);
        check("bus_b", bus_b, m_b);
        check("stall_cnt", {16'b0, stall_cnt}, m_cnt[31:0]);
    endtask

    task automatic clear_fwd();
        for (int i = 0; i < NF; i++) begin
            fv[i] = 1'b0;
            fa[i] = '0;
            fd[i] = '0;
            fr[i] = 1'b1;
        end
    endtask

    initial begin
        clear_fwd();
        reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        sa = 5'd1; sb = 5'd2; a_data = 32'd32; b_data = 33;
        pc = '0; im = '0; cs = 1'b0; ma = 1'b0; mb = 1'b0;

        // Reset with a request pending.
        repeat (2) begin
            cycle();
            check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        end
        check("rst_bus_a", bus_a, 32'd0);
        check("rst_stall", {16'b0, stall_cnt}, 32'd0);

        // Plain register-file select.
        reset_n = 1'b1;
        cycle();
        check("plain_a", bus_a, 32'd32);
        check("plain_b", bus_b, 32'd33);
        check("plain_valid", {31'b0, out_valid}, 32'd1);

        // PC_1 and zero-extended immediate.
        ma = 1'b1; mb = 1'b1; pc = 16'd5; im = 15'd15; cs = 1'b0;
        cycle();
        check("pc_a", bus_a, 32'd5);
        check("imm_zext", bus_b, 32'd15);

        // Sign-extended immediate.
        im = 15'h7FF0; cs = 1'b1;
        cycle();
        check("imm_sext", bus_b, 32'hFFFF_FFF0);

        // Youngest matching stage wins.
        ma = 1'b0; mb = 1'b0; sa = 5'd1; sb = 5'd1;
        fv[0] = 1'b1; fv[1] = 1'b1; fa[0] = 5'd1; fa[1] = 5'd1;
        fd[0] = 32'd34; fd[1] = 32'd99;
        cycle();
        check("fwd_prio_a", bus_a, 32'd34);
        check("fwd_prio_b", bus_b, 32'd34);

        // Register 0 is never forwarded.
        sa = 5'd0; fa[0] = 5'd0; fa[1] = 5'd0;
        cycle();
        check("r0_nofwd", bus_a, 32'd32);

        // Load-use: youngest stage matches sa but its result is not ready.
        sa = 5'd1; sb = 5'd2; fv[1] = 1'b0; fa[0] = 5'd1; fr[0] = 1'b0; fd[0] = 32'd55;
        repeat (2) begin
            cycle();
            check("lu_in_ready", {31'b0, in_ready}, 32'd0);
        end
        check("lu_stall_cnt", {16'b0, stall_cnt}, 32'd2);
        fr[0] = 1'b1; fd[0] = 32'd77;
        cycle();
        check("lu_release", bus_a, 32'd77);

        // Backpressure: output held, no stall counted.
        fv[0] = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_data = 32'd200 + 32'(k);
            cycle();
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_hold_a", bus_a, 32'd77);
            check("bp_stall", {16'b0, stall_cnt}, 32'd2);
        end
        out_ready = 1'b1; a_data = 32'd500;
        cycle();
        check("bp_release", bus_a, 32'd500);

        // Reset in the middle of a stall.
        fv[0] = 1'b1; fa[0] = 5'd1; fr[0] = 1'b0;
        cycle();
        check("ms_stall3", {16'b0, stall_cnt}, 32'd3);
        reset_n = 1'b0;
        cycle();
        check("ms_rst_cnt", {16'b0, stall_cnt}, 32'd0);
        check("ms_rst_valid", {31'b0, out_valid}, 32'd0);
        check("ms_rst_b", bus_b, 32'd0);
        reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset_n   = ($urandom_range(0, 79) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sa = 5'($urandom_range(0, 3));
            sb = 5'($urandom_range(0, 3));
            a_data = $urandom; b_data = $urandom;
            pc = 16'($urandom); im = 15'($urandom);
            cs = 1'($urandom); ma = ($urandom_range(0, 3) == 0); mb = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NF; i++) begin
                fv[i] = 1'($urandom);
                fa[i] = 5'($urandom_range(0, 3));
                fd[i] = $urandom;
                fr[i] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end

        // Saturation of the stall counter.
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1; ma = 1'b0; mb = 1'b1;
        clear_fwd();
        sa = 5'd3; fv[0] = 1'b1; fa[0] = 5'd3; fr[0] = 1'b0;
        for (int n = 0; n < 65540; n++) cycle();
        check("stall_sat", {16'b0, stall_cnt}, 32'h0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fwd_stage.md
Name: operand_fwd_stage

Overview:
- Registered operand-select stage for the RISC datapath. It is the parametrised successor of the combinational A/B bus mux.
- Drives Bus_A/Bus_B from register-file data, PC_1 or the extended immediate. Hazards are detected automatically against NUM_FWD in-flight pipeline stages, replacing the explicit HA/HB controls.
- Forwards the youngest matching result, stalls on load-use, and presents operands through a valid/ready pipeline register to the execute stage.

Parameters:
- DATA_W, 32, operand/bus width
- PC_W, 16, PC_1 width (PC_W <= DATA_W)
- IM_W, 15, immediate width (IM_W <= DATA_W)
- AW, 5, register address width
- NUM_FWD, 2, forwarding sources; index 0 = youngest stage
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  decode presents an operand request
- in_ready  out  1  request accepted this cycle
- sa  in  AW  source register address, operand A
- sb  in  AW  source register address, operand B
- A_Data  in  DATA_W  register-file read port A
- B_Data  in  DATA_W  register-file read port B
- PC_1  in  PC_W  incremented PC
- IM  in  IM_W  immediate field
- CS  in  1  1 = sign-extend IM, 0 = zero-extend
- MA  in  1  1 = Bus_A takes PC_1
- MB  in  1  1 = Bus_B takes extended IM
- fwd_valid  in  NUM_FWD  stage i writes a register
- fwd_addr  in  NUM_FWD*AW  destination of stage i (slice i)
- fwd_data  in  NUM_FWD*DATA_W  result of stage i (slice i)
- fwd_ready  in  NUM_FWD  stage i result available (0 = load pending)
- out_valid  out  1  Bus_A/Bus_B hold a valid operand pair
- out_ready  in  1  execute stage accepts
- Bus_A  out  DATA_W  registered operand A
- Bus_B  out  DATA_W  registered operand B
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (reset_n = 0 at edge): out_valid = 0, Bus_A = 0, Bus_B = 0, stall_cnt = 0. in_ready is forced to 0 while reset_n = 0. Reset overrides any in-progress stall or held output.
- Match rule: stage i matches source s when fwd_valid[i] = 1, fwd_addr[i] == s and s != 0. Register 0 is never forwarded.
- Winner: the lowest matching index.
- A_sel (combinational):
  - MA = 1: zero-extended PC_1.
  - MA = 0 and winner exists: fwd_data[winner].
  - Otherwise: A_Data.
- B_sel (combinational):
  - MB = 1: IM extended to DATA_W per CS.
  - MB = 0 and winner exists: fwd_data[winner].
  - Otherwise: B_Data.
- Hazard: in_valid = 1 and (operand A has MA = 0 with winner fwd_ready = 0, or operand B has MB = 0 with winner fwd_ready = 0). An older ready stage never masks a younger not-ready one.
- in_ready = reset_n & ~hazard & (~out_valid | out_ready).
- Capture (in_valid & in_ready): Bus_A <= A_sel, Bus_B <= B_sel, out_valid <= 1. Latency is one cycle.
- No capture: if out_ready = 1, out_valid <= 0; Bus_A/Bus_B hold their last values.
- Output stability: while out_valid = 1 and out_ready = 0, Bus_A/Bus_B must not change.
- Simultaneous consume and capture: when out_valid = 1, out_ready = 1 and a new request is captured in the same cycle, out_valid stays 1 and the new data is loaded (full throughput).
- stall_cnt increments by 1 each cycle the hazard is asserted. It saturates at all ones. Backpressure-only stalls do not count.

Test Plan:
- Reset: reset_n = 0 for 2 cycles with in_valid = 1 -> in_ready = 0, out_valid = 0, Bus_A = Bus_B = 0, stall_cnt = 0.
- Plain select: sa = 1, sb = 2, A_Data = 32, B_Data = 33, fwd_valid = 0, out_ready = 1.
  - MA = MB = 0 -> next cycle Bus_A = 32, Bus_B = 33, out_valid = 1.
  - MA = MB = 1, PC_1 = 5, IM = 15, CS = 0 -> Bus_A = 5, Bus_B = 15.
  - IM = 15'h7FF0, CS = 1 -> Bus_B = 32'hFFFF_FFF0.
- Forward priority: fwd_valid = 2'b11, both fwd_addr = 1, fwd_data = {99, 34}, fwd_ready = 2'b11, sa = sb = 1 -> Bus_A = Bus_B = 34.
  - Same with sa = 0 and fwd_addr = 0 -> Bus_A = A_Data = 32.
- Load-use: fwd_ready[0] = 0 matching sa for 2 cycles -> in_ready = 0, stall_cnt = 2, no capture.
  - Then fwd_ready[0] = 1, fwd_data[0] = 77 -> Bus_A = 77 one cycle later.
- Backpressure: out_valid = 1, out_ready = 0 for 3 cycles while A_Data changes -> in_ready = 0, Bus_A stable, stall_cnt unchanged.
  - out_ready = 1 -> new value captured.
- Reset mid-stall: stall_cnt = 3, hazard active, reset_n = 0 one cycle -> stall_cnt = 0, out_valid = 0, Bus_A = Bus_B = 0.
